// File: rtl/tile_sched_pkg.sv
// tile_sched_pkg: shared types for the layer tile scheduler.
// Holds the FSM state enum, the layer descriptor and default widths.
package tile_sched_pkg;

  localparam int TS_ROW_W  = 16;
  localparam int TS_TILE_W = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_RUN,
    S_NEXT,
    S_DONE
  } tile_sched_state_t;

  typedef struct packed {
    logic [TS_ROW_W-1:0]  num_row;
    logic [TS_TILE_W-1:0] num_wtile;
    logic [TS_TILE_W-1:0] num_itile;
    logic                 dbuf;
  } tile_cfg_t;

endpackage

// File: rtl/tile_sched_if.sv
// tile_sched_if: descriptor handshake, compute controller and status bus.
// slave = scheduler side, master = decoder / controller side.
interface tile_sched_if #(
  parameter int DATA_WIDTH = 16,
  parameter int TILE_W     = 8
);
  logic                  cfg_valid;
  logic                  cfg_ready;
  logic [DATA_WIDTH-1:0] cfg_num_row;
  logic [TILE_W-1:0]     cfg_num_wtile;
  logic [TILE_W-1:0]     cfg_num_itile;
  logic                  cfg_dbuf;
  logic                  ctrl_en;
  logic                  ctrl_weight_fill;
  logic                  ctrl_weight_change;
  logic [DATA_WIDTH-1:0] ctrl_num_row;
  logic                  fill_done;
  logic                  sys_done;
  logic                  busy;
  logic                  layer_done;
  logic [TILE_W-1:0]     wtile_idx;
  logic [TILE_W-1:0]     itile_idx;
  logic                  cfg_err;

  modport slave (
    input  cfg_valid, cfg_num_row, cfg_num_wtile,
    input  cfg_num_itile, cfg_dbuf,
    input  fill_done, sys_done,
    output cfg_ready, ctrl_en, ctrl_weight_fill,
    output ctrl_weight_change, ctrl_num_row,
    output busy, layer_done, wtile_idx, itile_idx,
    output cfg_err
  );

  modport master (
    output cfg_valid, cfg_num_row, cfg_num_wtile,
    output cfg_num_itile, cfg_dbuf,
    output fill_done, sys_done,
    input  cfg_ready, ctrl_en, ctrl_weight_fill,
    input  ctrl_weight_change, ctrl_num_row,
    input  busy, layer_done, wtile_idx, itile_idx,
    input  cfg_err
  );
endinterface

// File: rtl/tile_sched_counter.sv
// tile_counter: nested input/weight tile index counter with wrap.
// Ports: clr/step controls, tile limits in, indices and last flags out.
module tile_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         clr,
  input  logic         step,
  input  logic [W-1:0] num_itile,
  input  logic [W-1:0] num_wtile,
  output logic [W-1:0] itile_idx,
  output logic [W-1:0] wtile_idx,
  output logic         itile_last,
  output logic         wtile_last,
  output logic         last
);

  assign itile_last = itile_idx == num_itile - W'(1);
  assign wtile_last = wtile_idx == num_wtile - W'(1);
  assign last       = itile_last && wtile_last;

  always_ff @(posedge clk) begin
    if (!rstn || clr) begin
      itile_idx <= '0;
      wtile_idx <= '0;
    end else if (step) begin
      if (itile_last) begin
        itile_idx <= '0;
        wtile_idx <= wtile_last ? '0 : wtile_idx + W'(1);
      end else begin
        itile_idx <= itile_idx + W'(1);
      end
    end
  end

endmodule

// File: rtl/tile_sched.sv
// tile_sched: sequences tile start pulses over a tiled matmul layer.
// Ports: clk, rstn (sync, active-low), bus (descriptor/ctrl/status).
module tile_sched
  import tile_sched_pkg::*;
#(
  parameter int DATA_WIDTH = TS_ROW_W,
  parameter int TILE_W     = TS_TILE_W
) (
  input logic         clk,
  input logic         rstn,
  tile_sched_if.slave bus
);

  tile_sched_state_t     state_q, state_d;
  tile_cfg_t             cfg_q, cfg_d;
  logic [DATA_WIDTH-1:0] row_q, row_d;
  logic pf_pend_q, pf_pend_d;
  logic pf_mark_q, pf_mark_d;
  logic first_q, first_d;
  logic ready_q, ready_d;
  logic en_q, en_d;
  logic fill_q, fill_d;
  logic chg_q, chg_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic err_q, err_d;
  logic cnt_clr, cnt_step, pf_set;
  logic cfg_zero, row_end;
  logic i_last, w_last, t_last;
  logic [TILE_W-1:0] w_idx, i_idx;

  tile_counter #(.W(TILE_W)) u_cnt (
    .clk        (clk),
    .rstn       (rstn),
    .clr        (cnt_clr),
    .step       (cnt_step),
    .num_itile  (cfg_q.num_itile),
    .num_wtile  (cfg_q.num_wtile),
    .itile_idx  (i_idx),
    .wtile_idx  (w_idx),
    .itile_last (i_last),
    .wtile_last (w_last),
    .last       (t_last)
  );

  assign cfg_zero = (bus.cfg_num_row == '0)
                 || (bus.cfg_num_wtile == '0)
                 || (bus.cfg_num_itile == '0);
  assign row_end  = row_q == cfg_q.num_row - DATA_WIDTH'(1);

  always_comb begin
    state_d   = state_q;
    cfg_d     = cfg_q;
    row_d     = row_q;
    pf_pend_d = pf_pend_q;
    pf_mark_d = pf_mark_q;
    first_d   = 1'b0;
    ready_d   = 1'b0;
    en_d      = 1'b0;
    fill_d    = 1'b0;
    chg_d     = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    cnt_clr   = 1'b0;
    cnt_step  = 1'b0;
    pf_set    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        ready_d = 1'b1;
        if (bus.cfg_valid) begin
          cfg_d.num_row   = bus.cfg_num_row;
          cfg_d.num_wtile = bus.cfg_num_wtile;
          cfg_d.num_itile = bus.cfg_num_itile;
          cfg_d.dbuf      = bus.cfg_dbuf;
          if (cfg_zero) begin
            err_d = 1'b1;
          end else begin
            ready_d   = 1'b0;
            busy_d    = 1'b1;
            cnt_clr   = 1'b1;
            row_d     = '0;
            pf_pend_d = 1'b0;
            pf_mark_d = 1'b0;
            state_d   = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (!pf_pend_q) begin
          en_d    = 1'b1;
          first_d = 1'b1;
          if (i_idx == '0) begin
            // a prefetched weight tile is already resident
            fill_d    = !pf_mark_q;
            pf_mark_d = 1'b0;
          end
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (first_q && cfg_q.dbuf && i_last && !w_last) begin
          chg_d     = 1'b1;
          pf_set    = 1'b1;
          pf_mark_d = 1'b1;
        end
        if (bus.sys_done) begin
          if (row_end) begin
            row_d   = '0;
            state_d = S_NEXT;
          end else begin
            row_d = row_q + DATA_WIDTH'(1);
          end
        end
      end
      S_NEXT: begin
        cnt_step = 1'b1;
        state_d  = t_last ? S_DONE : S_ISSUE;
      end
      S_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        ready_d = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        ready_d = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
    // set only happens in the first RUN cycle, so it wins a tie
    if (pf_set) begin
      pf_pend_d = 1'b1;
    end else if (bus.fill_done) begin
      pf_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      cfg_q     <= '0;
      row_q     <= '0;
      pf_pend_q <= 1'b0;
      pf_mark_q <= 1'b0;
      first_q   <= 1'b0;
      ready_q   <= 1'b1;
      en_q      <= 1'b0;
      fill_q    <= 1'b0;
      chg_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cfg_q     <= cfg_d;
      row_q     <= row_d;
      pf_pend_q <= pf_pend_d;
      pf_mark_q <= pf_mark_d;
      first_q   <= first_d;
      ready_q   <= ready_d;
      en_q      <= en_d;
      fill_q    <= fill_d;
      chg_q     <= chg_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign bus.cfg_ready          = ready_q;
  assign bus.ctrl_en            = en_q;
  assign bus.ctrl_weight_fill   = fill_q;
  assign bus.ctrl_weight_change = chg_q;
  assign bus.ctrl_num_row       = cfg_q.num_row;
  assign bus.busy               = busy_q;
  assign bus.layer_done         = done_q;
  assign bus.wtile_idx          = w_idx;
  assign bus.itile_idx          = i_idx;
  assign bus.cfg_err            = err_q;

endmodule

// File: tb/tb_tile_sched.sv
// tb_tile_sched: self-checking bench for tile_sched.
// Acts as decoder and compute controller against a tile-order model.
module tb_tile_sched;

  logic clk;
  logic rstn;
  int   checks;
  int   errors;

  tile_sched_if #(.DATA_WIDTH(16), .TILE_W(8)) bus ();

  tile_sched #(.DATA_WIDTH(16), .TILE_W(8)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    tick();
    tick();
    checks++;
    if (bus.cfg_ready !== 1'b1 || bus.busy !== 1'b0
        || bus.ctrl_en !== 1'b0 || bus.layer_done !== 1'b0
        || bus.cfg_err !== 1'b0
        || bus.ctrl_weight_fill !== 1'b0
        || bus.ctrl_weight_change !== 1'b0
        || bus.wtile_idx !== 8'd0 || bus.itile_idx !== 8'd0
        || bus.ctrl_num_row !== 16'd0) begin
      errors++;
      $display("FAIL reset_state: rdy=%b busy=%b en=%b ld=%b err=%b w=%0d i=%0d nr=%0d want rdy=1 rest 0",
               bus.cfg_ready, bus.busy, bus.ctrl_en, bus.layer_done,
               bus.cfg_err, bus.wtile_idx, bus.itile_idx,
               bus.ctrl_num_row);
    end
    rstn = 1'b1;
    tick();
  endtask

  // Runs one full layer; the expected tile order, fill/prefetch flags
  // and tile timing come from nested-loop arithmetic over (w, i).
  task automatic run_layer(input int nr, input int nw, input int ni,
                           input bit dbuf, input int fdly,
                           input bit stray);
    int total, k, rows_left, tn, last_sys, en_tick;
    int fill_cnt, fill_tick, changes, exp_changes;
    int w, i, exp_t;
    bit done, exp_fill, waited, exp_chg;
    total       = nw * ni;
    k           = 0;
    rows_left   = 0;
    last_sys    = -100;
    en_tick     = -100;
    fill_cnt    = -1;
    fill_tick   = -100;
    changes     = 0;
    exp_changes = dbuf ? nw - 1 : 0;
    done        = 1'b0;
    bus.cfg_valid     = 1'b1;
    bus.cfg_num_row   = 16'(nr);
    bus.cfg_num_wtile = 8'(nw);
    bus.cfg_num_itile = 8'(ni);
    bus.cfg_dbuf      = dbuf;
    tick();
    bus.cfg_valid = 1'b0;
    checks++;
    if (bus.busy !== 1'b1 || bus.cfg_ready !== 1'b0
        || bus.ctrl_num_row !== 16'(nr)) begin
      errors++;
      $display("FAIL accept: busy=%b rdy=%b nr=%0d want busy=1 rdy=0 nr=%0d",
               bus.busy, bus.cfg_ready, bus.ctrl_num_row, nr);
    end
    tn = 0;
    if (stray) bus.sys_done = 1'b1;
    for (int b = 0; b < 3000 && !done; b++) begin
      tick();
      tn++;
      bus.sys_done  = 1'b0;
      bus.fill_done = 1'b0;
      if (bus.layer_done === 1'b1) begin
        checks++;
        if (k != total || rows_left != 0 || tn != last_sys + 3
            || bus.busy !== 1'b0 || bus.cfg_ready !== 1'b1
            || changes != exp_changes) begin
          errors++;
          $display("FAIL layer_done: tiles=%0d/%0d rows_left=%0d t=%0d want t=%0d busy=%b rdy=%b chg=%0d want %0d",
                   k, total, rows_left, tn, last_sys + 3, bus.busy,
                   bus.cfg_ready, changes, exp_changes);
        end
        done = 1'b1;
      end else begin
        checks++;
        if (bus.busy !== 1'b1) begin
          errors++;
          $display("FAIL busy_run: got %b want 1 at t=%0d",
                   bus.busy, tn);
        end
      end
      if (bus.ctrl_en === 1'b1) begin
        w        = k / ni;
        i        = k % ni;
        exp_fill = (i == 0) && !(dbuf && w > 0);
        waited   = dbuf && i == 0 && w > 0;
        checks++;
        if (k >= total || rows_left != 0 || bus.wtile_idx !== 8'(w)
            || bus.itile_idx !== 8'(i)
            || bus.ctrl_weight_fill !== exp_fill) begin
          errors++;
          $display("FAIL tile_issue: k=%0d w=%0d i=%0d fill=%b want w=%0d i=%0d fill=%b rows_left=%0d",
                   k, bus.wtile_idx, bus.itile_idx,
                   bus.ctrl_weight_fill, w, i, exp_fill, rows_left);
        end
        if (k == 0) begin
          exp_t = 1;
        end else begin
          exp_t = last_sys + 3;
          if (waited && fill_tick + 2 > exp_t) exp_t = fill_tick + 2;
        end
        checks++;
        if (tn != exp_t) begin
          errors++;
          $display("FAIL tile_timing: k=%0d t=%0d want %0d",
                   k, tn, exp_t);
        end
        rows_left = nr;
        en_tick   = tn;
        k++;
      end
      if (bus.ctrl_weight_change === 1'b1) begin
        changes++;
        exp_chg = 1'b0;
        if (k > 0) begin
          w = (k - 1) / ni;
          i = (k - 1) % ni;
          exp_chg = dbuf && i == ni - 1 && w < nw - 1;
        end
        checks++;
        if (!exp_chg || tn != en_tick + 1) begin
          errors++;
          $display("FAIL weight_change: tile=%0d t=%0d want t=%0d expected=%b",
                   k - 1, tn, en_tick + 1, exp_chg);
        end
        fill_cnt = fdly;
      end
      if (!done) begin
        if (fill_cnt == 0) begin
          bus.fill_done = 1'b1;
          fill_tick     = tn;
          fill_cnt      = -1;
        end else if (fill_cnt > 0) begin
          fill_cnt--;
        end
        if (rows_left > 0 && $urandom_range(0, 2) != 0) begin
          bus.sys_done = 1'b1;
          rows_left--;
          last_sys = tn;
        end
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL layer_timeout: tiles=%0d/%0d no layer_done",
               k, total);
    end
    bus.sys_done  = 1'b0;
    bus.fill_done = 1'b0;
    tick();
    checks++;
    if (bus.layer_done !== 1'b0 || bus.cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL post_layer: ld=%b rdy=%b want ld=0 rdy=1",
               bus.layer_done, bus.cfg_ready);
    end
  endtask

  task automatic test_basic();
    run_layer(4, 1, 1, 1'b0, 0, 1'b0);
  endtask

  task automatic test_multi_tile();
    run_layer(2, 2, 3, 1'b0, 0, 1'b0);
  endtask

  task automatic test_double_buffer();
    run_layer(2, 2, 3, 1'b1, 20, 1'b0);
    run_layer(2, 2, 3, 1'b1, 0, 1'b0);
    run_layer(3, 3, 1, 1'b1, 5, 1'b0);
  endtask

  task automatic test_bad_cfg();
    bus.cfg_valid     = 1'b1;
    bus.cfg_num_row   = 16'd4;
    bus.cfg_num_wtile = 8'd2;
    bus.cfg_num_itile = 8'd0;
    bus.cfg_dbuf      = 1'b0;
    tick();
    bus.cfg_valid = 1'b0;
    checks++;
    if (bus.cfg_err !== 1'b1 || bus.busy !== 1'b0
        || bus.cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL bad_cfg: err=%b busy=%b rdy=%b want 1 0 1",
               bus.cfg_err, bus.busy, bus.cfg_ready);
    end
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++;
      if (bus.cfg_err !== 1'b0 || bus.busy !== 1'b0
          || bus.ctrl_en !== 1'b0) begin
        errors++;
        $display("FAIL bad_cfg_after: err=%b busy=%b en=%b want 0 0 0",
                 bus.cfg_err, bus.busy, bus.ctrl_en);
      end
    end
  endtask

  task automatic test_stray();
    for (int c = 0; c < 3; c++) begin
      bus.sys_done = 1'b1;
      tick();
    end
    bus.sys_done = 1'b0;
    tick();
    run_layer(3, 2, 2, 1'b0, 0, 1'b1);
  endtask

  task automatic test_reset_mid_run();
    bit seen;
    seen = 1'b0;
    bus.cfg_valid     = 1'b1;
    bus.cfg_num_row   = 16'd4;
    bus.cfg_num_wtile = 8'd1;
    bus.cfg_num_itile = 8'd1;
    bus.cfg_dbuf      = 1'b0;
    tick();
    bus.cfg_valid = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      tick();
      if (bus.ctrl_en === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL rst_mid_issue: got no ctrl_en want one");
    end
    bus.sys_done = 1'b1;
    tick();
    tick();
    bus.sys_done = 1'b0;
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    checks++;
    if (bus.cfg_ready !== 1'b1 || bus.busy !== 1'b0
        || bus.ctrl_en !== 1'b0 || bus.layer_done !== 1'b0
        || bus.wtile_idx !== 8'd0 || bus.itile_idx !== 8'd0
        || bus.ctrl_num_row !== 16'd0) begin
      errors++;
      $display("FAIL rst_mid_state: rdy=%b busy=%b en=%b ld=%b nr=%0d want rdy=1 rest 0",
               bus.cfg_ready, bus.busy, bus.ctrl_en,
               bus.layer_done, bus.ctrl_num_row);
    end
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++;
      if (bus.layer_done !== 1'b0 || bus.ctrl_en !== 1'b0) begin
        errors++;
        $display("FAIL rst_mid_quiet: ld=%b en=%b want 0 0",
                 bus.layer_done, bus.ctrl_en);
      end
    end
    run_layer(4, 1, 1, 1'b0, 0, 1'b0);
  endtask

  task automatic test_random();
    int nr, nw, ni, fd;
    bit db, st;
    for (int n = 0; n < 10; n++) begin
      nr = int'($urandom_range(1, 4));
      nw = int'($urandom_range(1, 3));
      ni = int'($urandom_range(1, 3));
      fd = int'($urandom_range(0, 25));
      db = 1'($urandom_range(0, 1));
      st = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 3)) tick();
      run_layer(nr, nw, ni, db, fd, st);
    end
  endtask

  initial begin
    checks            = 0;
    errors            = 0;
    rstn              = 1'b0;
    bus.cfg_valid     = 1'b0;
    bus.cfg_num_row   = 16'd0;
    bus.cfg_num_wtile = 8'd0;
    bus.cfg_num_itile = 8'd0;
    bus.cfg_dbuf      = 1'b0;
    bus.fill_done     = 1'b0;
    bus.sys_done      = 1'b0;
    test_reset();
    test_basic();
    test_multi_tile();
    test_double_buffer();
    test_bad_cfg();
    test_stray();
    test_reset_mid_run();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/tile_sched.md
Name: tile_sched

Overview:
- Layer-level scheduler that sequences the compute controller over a tiled matrix multiply.
- Accepts one layer descriptor: rows per tile, number of weight tiles, number of input tiles per weight tile.
- Issues per-tile start pulses with weight-fill / weight-change (double-buffer prefetch) qualifiers.
- Counts row completions (`sys_done` pulses) to detect tile end and reports layer completion.
- Sits between the command decoder and the compute controller.

Parameters:
- DATA_WIDTH, 16, width of row count (matches the compute controller `num_row_in`).
- TILE_W, 8, width of the tile counters.

Ports:
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- cfg_valid  in  1  layer descriptor valid
- cfg_ready  out  1  scheduler can accept a descriptor
- cfg_num_row  in  DATA_WIDTH  rows per tile (sys_done pulses per tile)
- cfg_num_wtile  in  TILE_W  weight tiles in the layer
- cfg_num_itile  in  TILE_W  input tiles per weight tile
- cfg_dbuf  in  1  1 = prefetch next weights during the last input tile
- ctrl_en  out  1  one-cycle tile start pulse to the compute controller
- ctrl_weight_fill  out  1  qualifies ctrl_en: load weights before compute
- ctrl_weight_change  out  1  one-cycle prefetch request for the next weight tile
- ctrl_num_row  out  DATA_WIDTH  latched cfg_num_row, stable while busy
- fill_done  in  1  weight fill complete pulse
- sys_done  in  1  one row of results complete pulse
- busy  out  1  layer in progress
- layer_done  out  1  one-cycle pulse after the final row of the final tile
- wtile_idx  out  TILE_W  current weight tile index
- itile_idx  out  TILE_W  current input tile index
- cfg_err  out  1  one-cycle pulse when a descriptor with a zero field is rejected

Behaviour:
- All outputs are registered. Reset values:
  - cfg_ready = 1.
  - All pulses = 0.
  - busy = 0.
  - Indices = 0.
  - ctrl_num_row = 0.
  - State = IDLE.
  - row_cnt = 0.
  - pf_pending = 0.
- States: IDLE, ISSUE, RUN, NEXT, DONE.
- IDLE: cfg_ready = 1.
  - On cfg_valid, latch all cfg fields.
  - If any of num_row, num_wtile, num_itile is 0: pulse cfg_err the next cycle and stay in IDLE.
  - Otherwise: cfg_ready = 0, busy = 1, go to ISSUE.
- ISSUE: wait until pf_pending = 0, then pulse ctrl_en for one cycle and go to RUN.
  - ctrl_weight_fill = 1 when itile_idx = 0 and the current weight tile was not prefetched; otherwise 0.
- RUN: row_cnt increments on each sys_done.
  - When row_cnt reaches ctrl_num_row − 1 and sys_done is high: row_cnt is cleared and the state goes to NEXT.
  - Prefetch: when cfg_dbuf = 1, itile_idx = num_itile − 1 and wtile_idx < num_wtile − 1, pulse ctrl_weight_change exactly once, in the first RUN cycle.
  - The prefetch pulse sets pf_pending and marks the next weight tile as prefetched.
- pf_pending is cleared by fill_done.
  - fill_done arriving in the same cycle as the set: set wins if it is the first cycle; otherwise clear.
- fill_done pulses that are not prefetch-related are ignored. The compute controller gates its own compute start.
- NEXT: advance the indices.
  - itile_idx + 1, wrapping to 0 at num_itile; wtile_idx increments on that wrap.
  - If both counters were at their last value: go to DONE. Otherwise go to ISSUE.
- NEXT to ISSUE is one cycle. Minimum tile period is 3 cycles plus rows.
- DONE: pulse layer_done, clear busy, go to IDLE. cfg_ready = 1 the following cycle.
- sys_done seen in IDLE, ISSUE, NEXT or DONE is ignored (no count).
- Reset mid-operation: reset values on the next edge; no pulses are emitted.
- Counter arithmetic is modulo the field width.
  - num_row = 1 is legal: one sys_done ends the tile.
  - Maximum num_wtile × num_itile = (2^TILE_W − 1)².

Decomposition:
- Shared package (e.g. neurex_ctrl_pkg) holds:
  - the state enum tile_sched_state_t;
  - the descriptor struct tile_cfg_t (num_row, num_wtile, num_itile, dbuf).
- One sub-module, tile_counter: nested itile/wtile wrap counter.
  - Inputs: step, limits.
  - Outputs: indices, last flag.
  - Reused by the later output-store scheduler.

Test Plan:
- Basic layer: cfg num_row=4, wtile=1, itile=1, dbuf=0.
  - 1 ctrl_en with weight_fill=1.
  - After the 4th sys_done: layer_done pulse 3 cycles later, busy drops, cfg_ready=1.
- Multi-tile: num_row=2, wtile=2, itile=3, dbuf=0.
  - 6 ctrl_en pulses; weight_fill=1 only at (w0,i0) and (w1,i0).
  - Indices follow (0,0),(0,1),(0,2),(1,0),(1,1),(1,2).
- Double buffer: same descriptor with dbuf=1.
  - ctrl_weight_change pulses once at (w0,i2).
  - (w1,i0) has weight_fill=0.
  - If fill_done is withheld for 20 cycles, the (w1,i0) ctrl_en is delayed until 1 cycle after fill_done.
- Bad config: num_itile=0 → cfg_err pulse, busy stays 0, no ctrl_en.
- Stray events: sys_done pulses in IDLE and in ISSUE do not change row_cnt; the next tile still needs the full num_row pulses.
- Reset mid-RUN: rstn low for 1 cycle at row 2 of 4.
  - All outputs at reset values; no layer_done pulse.
  - A new descriptor is accepted immediately afterwards.
